// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Imported by the arbiter top and its scoreboard.
package rf_arb_pkg;

    typedef logic [4:0]  regsel_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        PRIO0  = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination bit vector for multicycle results.
// Register 0 is never pending; a same-cycle set beats a clear.
module rf_scoreboard
    import rf_arb_pkg::*;
#(
    parameter int NREG = 32,
    localparam int SW = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          set_en_i,
    input  logic [SW-1:0] set_sel_i,
    input  logic          clr_en_i,
    input  logic [SW-1:0] clr_sel_i,
    input  logic [SW-1:0] rsel_a_i,
    input  logic [SW-1:0] rsel_b_i,
    output logic          hit_a_o,
    output logic          hit_b_o
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Next pending vector: clear first so a set to the same bit wins
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_sel_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_sel_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hit_a_o = pending_q[rsel_a_i];
    assign hit_b_o = pending_q[rsel_b_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback and the
// multicycle unit, with starvation forcing and a pending scoreboard.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    localparam int SW = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [SW-1:0] req0_sel,
    input  logic [DW-1:0] req0_dat,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [SW-1:0] req1_sel,
    input  logic [DW-1:0] req1_dat,
    input  logic          issue_valid,
    input  logic [SW-1:0] issue_sel,
    input  logic [SW-1:0] rsel1,
    input  logic [SW-1:0] rsel2,
    output logic          stall,
    output logic          WEN,
    output logic [SW-1:0] wsel,
    output logic [DW-1:0] wdat
);

    localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] cnt_q, cnt_d;
    logic                xfer0, xfer1;
    logic                wen_q;
    logic [SW-1:0]       wsel_q;
    logic [DW-1:0]       wdat_q;
    logic                hit1, hit2;

    // Ready signals depend only on state and req0_valid
    always_comb begin
        req0_ready = 1'b1;
        req1_ready = !req0_valid;
        if (state_q == FORCE1) begin
            req0_ready = 1'b0;
            req1_ready = 1'b1;
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    // Starve count and arbitration state next values
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (xfer1 || !req1_valid) begin
            cnt_d = '0;
        end else if (cnt_q < SMAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        unique case (state_q)
            PRIO0: begin
                if (cnt_d == SMAX) begin
                    state_d = FORCE1;
                end
            end
            FORCE1: begin
                if (xfer1 || !req1_valid) begin
                    state_d = PRIO0;
                end
            end
            default: state_d = PRIO0;
        endcase
    end

    // Arbitration FSM and starve counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= PRIO0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered write port; register 0 transfers but never writes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen_q  <= 1'b0;
            wsel_q <= '0;
            wdat_q <= '0;
        end else if (xfer0) begin
            wen_q  <= |req0_sel;
            wsel_q <= req0_sel;
            wdat_q <= req0_dat;
        end else if (xfer1) begin
            wen_q  <= |req1_sel;
            wsel_q <= req1_sel;
            wdat_q <= req1_dat;
        end else begin
            wen_q  <= 1'b0;
        end
    end

    assign WEN  = wen_q;
    assign wsel = wsel_q;
    assign wdat = wdat_q;

    rf_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .CLK       (CLK),
        .nRST      (nRST),
        .set_en_i  (issue_valid),
        .set_sel_i (issue_sel),
        .clr_en_i  (xfer1),
        .clr_sel_i (req1_sel),
        .rsel_a_i  (rsel1),
        .rsel_b_i  (rsel2),
        .hit_a_o   (hit1),
        .hit_b_o   (hit2)
    );

    assign stall = hit1 | hit2;

endmodule
